// File: rtl/mul_feed_controller.sv
// mul_feed_controller: feeds column-ordered partial products to the shift register/compressor and checks the captured sum.
module mul_feed_controller #(
  parameter int N = 22,
  parameter int COMP_LATENCY = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [2*N-2:0]   shift_bits,
  input  logic [2*N-1:0]   sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   result,
  output logic [2*N-1:0]   expected,
  output logic             mismatch,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int W = 2*N-1;
  localparam int R = 2*N;
  localparam int CMAX = N > COMP_LATENCY+1 ? N : COMP_LATENCY+1;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int AW = N > 1 ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, feed_j;
  logic [N-1:0] op_a, op_b, src_a, src_b;
  logic [W-1:0] bits_n;
  logic accept, feed_on, capture, miss;

  assign accept = state == IDLE && in_valid;
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign miss = sum_in != expected;

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = in_valid ? FEED : IDLE;
        cnt_n = '0;
      end
      FEED: begin
        state_n = cnt == CW'(N-1) ? WAIT : FEED;
        cnt_n = cnt == CW'(N-1) ? '0 : cnt + 1'b1;
      end
      WAIT: begin
        capture = cnt == CW'(COMP_LATENCY);
        state_n = capture ? DONE : WAIT;
        cnt_n = cnt + 1'b1;
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  // shift_bits is registered, so compute the bits of the cycle about to start
  assign feed_on = accept || (state == FEED && cnt != CW'(N-1));
  assign feed_j = state == FEED ? cnt + 1'b1 : '0;
  assign src_a = state == FEED ? op_a : a;
  assign src_b = state == FEED ? op_b : b;

  for (genvar k = 0; k < W; k++) begin : g_col
    localparam int H = k+1 < W-k ? k+1 : W-k;
    localparam int OFF = N - H;
    localparam int IMIN = k-N+1 > 0 ? k-N+1 : 0;
    logic [AW-1:0] ia, ib;
    assign ia = AW'(IMIN + int'(feed_j) - OFF);
    assign ib = AW'(k - IMIN - int'(feed_j) + OFF);
    assign bits_n[k] = feed_on && int'(feed_j) >= OFF && src_a[ia] && src_b[ib];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_a <= '0;
      op_b <= '0;
      shift_bits <= '0;
      result <= '0;
      expected <= '0;
      mismatch <= 1'b0;
      op_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shift_bits <= bits_n;
      if (accept) begin
        op_a <= a;
        op_b <= b;
        expected <= R'(a) * R'(b);
      end
      if (capture) begin
        result <= sum_in;
        mismatch <= miss;
        op_count <= op_count + CNT_W'(op_count != '1);
        err_count <= err_count + CNT_W'(miss && err_count != '1);
      end
    end
  end
endmodule

// File: tb/tb_mul_feed_controller.sv
// tb_mul_feed_controller: two controllers (compressor latency 0 and 2) driving modelled shift register/compressor pairs.
module tb_mul_feed_controller;
  localparam int N = 22;
  localparam int W = 2*N-1;
  localparam int R = 2*N;
  localparam int CW = 16;

  typedef struct {
    int d;
    logic [N-1:0] a;
    logic [N-1:0] b;
    bit flt;
    int hold;
    bit fixed;
    logic [R-1:0] res;
    bit one;
    bit late;
  } vec_t;

  logic clk = 1'b0;
  logic rst [2];
  logic in_valid [2];
  logic in_ready [2];
  logic out_valid [2];
  logic out_ready [2];
  logic mismatch [2];
  logic inv5 [2];
  logic [N-1:0] a [2];
  logic [N-1:0] b [2];
  logic [W-1:0] shift_bits [2];
  logic [R-1:0] sum_in [2];
  logic [R-1:0] result [2];
  logic [R-1:0] expected [2];
  logic [CW-1:0] op_count [2];
  logic [CW-1:0] err_count [2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [R-1:0] prod [2];
  int ops [2];
  int errs [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int L = 2*g;
    logic [N-1:0] col [W];
    logic [R-1:0] raw, flip;
    mul_feed_controller #(.N(N), .COMP_LATENCY(L), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .a(a[g]), .b(b[g]), .shift_bits(shift_bits[g]), .sum_in(sum_in[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .result(result[g]),
      .expected(expected[g]), .mismatch(mismatch[g]),
      .op_count(op_count[g]), .err_count(err_count[g])
    );
    assign flip = R'(inv5[g]) << 5;
    always @(posedge clk)
      for (int k = 0; k < W; k++) col[k] <= {col[k][N-2:0], shift_bits[g][k]};
    always_comb begin
      raw = '0;
      for (int k = 0; k < W; k++)
        for (int t = 0; t < N; t++)
          if (t < ((k+1 < W-k) ? k+1 : W-k)) raw += R'(col[k][t]) << k;
    end
    if (L == 0) begin : comb_c
      assign sum_in[g] = raw ^ flip;
    end else begin : pipe_c
      logic [R-1:0] p [L];
      always @(posedge clk) begin
        p[0] <= raw;
        for (int i = 1; i < L; i++) p[i] <= p[i-1];
      end
      assign sum_in[g] = p[L-1] ^ flip;
    end
  end

  task automatic chk(input string nm, input logic [R-1:0] act, input logic [R-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic do_reset(input int d, input int cyc);
    rst[d] = 1'b1;
    repeat (cyc) @(negedge clk);
    chk("rst_in_ready", R'(in_ready[d]), '0);
    chk("rst_out_valid", R'(out_valid[d]), '0);
    chk("rst_result", result[d], '0);
    chk("rst_expected", expected[d], '0);
    chk("rst_mismatch", R'(mismatch[d]), '0);
    chk("rst_op_count", R'(op_count[d]), '0);
    chk("rst_err_count", R'(err_count[d]), '0);
    chk("rst_shift_bits", R'(shift_bits[d]), '0);
    rst[d] = 1'b0;
    #1;
    chk("post_rst_in_ready", R'(in_ready[d]), R'(1));
    ops[d] = 0;
    errs[d] = 0;
  endtask

  task automatic issue(input int d, input logic [N-1:0] av, input logic [N-1:0] bv, input bit flt);
    chk("idle_in_ready", R'(in_ready[d]), R'(1));
    a[d] = av;
    b[d] = bv;
    inv5[d] = flt;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    chk("busy_in_ready", R'(in_ready[d]), '0);
    prod[d] = R'(av) * R'(bv);
  endtask

  task automatic complete(input int d, input int hold, input bit rel, input bit late,
                          output logic [W-1:0] early_or, output logic [W-1:0] last_bits);
    int e;
    logic [R-1:0] fed, want;
    bit stray;
    e = 1;
    fed = '0;
    stray = 0;
    early_or = '0;
    last_bits = '0;
    while (!out_valid[d] && e < 64) begin
      if (e < N) early_or |= shift_bits[d];
      if (e == N) last_bits = shift_bits[d];
      if (e <= N) begin
        for (int k = 0; k < W; k++) fed += R'(shift_bits[d][k]) << k;
      end else stray |= shift_bits[d] != '0;
      @(negedge clk);
      e++;
    end
    chk("out_valid_latency", R'(e), R'(N + 2*d + 2));
    chk("fed_pp_sum", fed, prod[d]);
    chk("post_feed_bits_zero", R'(stray), '0);
    if (late) chk("late_capture_differs", R'(sum_in[d] != prod[d]), R'(1));
    want = prod[d] ^ (R'(inv5[d]) << 5);
    if (ops[d] < 65535) ops[d]++;
    if (inv5[d] && errs[d] < 65535) errs[d]++;
    chk("result", result[d], want);
    chk("expected", expected[d], prod[d]);
    chk("mismatch", R'(mismatch[d]), R'(inv5[d]));
    chk("op_count", R'(op_count[d]), R'(ops[d]));
    chk("err_count", R'(err_count[d]), R'(errs[d]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_result", result[d], want);
      chk("hold_out_valid", R'(out_valid[d]), R'(1));
      chk("hold_in_ready", R'(in_ready[d]), '0);
    end
    if (rel) begin
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
      chk("release_out_valid", R'(out_valid[d]), '0);
      chk("release_in_ready", R'(in_ready[d]), R'(1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    logic [W-1:0] eo, lb;
    int d;
    logic [N-1:0] ra, rb;
    tbl = '{
      '{0, 22'h00ABCD, 22'h012345, 1'b1, 0, 1'b0, 44'h0, 1'b0, 1'b0},
      '{0, 22'h3FFFFF, 22'h3FFFFF, 1'b0, 0, 1'b1, 44'hFFFFF800001, 1'b0, 1'b0},
      '{0, 22'h000001, 22'h000001, 1'b0, 0, 1'b1, 44'h1, 1'b1, 1'b0},
      '{1, 22'h155555, 22'h2AAAAA, 1'b0, 0, 1'b0, 44'h0, 1'b0, 1'b1},
      '{0, 22'h2AAAAA, 22'h155555, 1'b0, 10, 1'b0, 44'h0, 1'b0, 1'b0},
      '{1, 22'h000000, 22'h3FFFFF, 1'b0, 3, 1'b0, 44'h0, 1'b0, 1'b0},
      '{1, 22'h3FFFFF, 22'h000001, 1'b1, 1, 1'b0, 44'h0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
      inv5[i] = 1'b0;
      a[i] = '0;
      b[i] = '0;
    end
    do_reset(0, 3);
    do_reset(1, 3);

    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].flt);
      complete(tbl[i].d, tbl[i].hold, 1'b1, tbl[i].late, eo, lb);
      if (tbl[i].fixed) chk("fixed_result", result[tbl[i].d], tbl[i].res);
      if (tbl[i].one) begin
        chk("one_early_bits", R'(eo), '0);
        chk("one_last_bits", R'(lb), R'(1));
      end
    end

    // result released together with a new operand: accepted only one cycle later
    issue(0, 22'h0F0F0F, 22'h30C30C, 1'b0);
    complete(0, 2, 1'b0, 1'b0, eo, lb);
    a[0] = 22'h123456;
    b[0] = 22'h0FEDCB;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("simul_not_accepted", R'(in_ready[0]), R'(1));
    chk("simul_out_valid", R'(out_valid[0]), '0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("simul_accepted_next", R'(in_ready[0]), '0);
    prod[0] = R'(22'h123456) * R'(22'h0FEDCB);
    complete(0, 0, 1'b1, 1'b0, eo, lb);

    // reset in the middle of FEED, then a clean small operation
    issue(0, 22'h2F0F0F, 22'h001234, 1'b0);
    repeat (10) @(negedge clk);
    do_reset(0, 1);
    issue(0, 22'd3, 22'd5, 1'b0);
    complete(0, 0, 1'b1, 1'b0, eo, lb);
    chk("after_abort_result", result[0], 44'd15);
    chk("after_abort_op_count", R'(op_count[0]), R'(1));

    for (int i = 0; i < 16; i++) begin
      d = i % 2;
      ra = N'($urandom);
      rb = N'($urandom);
      issue(d, ra, rb, $urandom_range(0, 3) == 0);
      complete(d, $urandom_range(0, 3), 1'b1, 1'b0, eo, lb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
